// File: rtl/pdp8_mem_pkg.sv
// rtl/pdp8_mem_pkg.sv - shared types and constants for the main-memory arbiter.
// Optional build macro MEM_ARB_FAIR_EN is consumed by mem_arbiter.
package pdp8_mem_pkg;

   localparam int DEF_AW = 15;
   localparam int DEF_DW = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Owner IDs double as bit positions in the one-hot winner vector.
   typedef enum logic [1:0] {
      OWN_BRK = 2'd0,
      OWN_CON = 2'd1,
      OWN_CPU = 2'd2
   } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner selection: BRK > CON > CPU.
// CON is ineligible while the CPU runs; force_cpu overrides priority for a requesting CPU.
module mem_arb_pick
   import pdp8_mem_pkg::*;
(
   input  logic       brk_req,
   input  logic       con_req,
   input  logic       cpu_req,
   input  logic       cpu_run,
   input  logic       force_cpu,
   output logic [2:0] win,
   output logic       valid
);

   always_comb begin
      win = 3'b000;
      if (force_cpu && cpu_req)
         win[OWN_CPU] = 1'b1;
      else if (brk_req)
         win[OWN_BRK] = 1'b1;
      else if (con_req && !cpu_run)
         win[OWN_CON] = 1'b1;
      else if (cpu_req)
         win[OWN_CPU] = 1'b1;
   end

   assign valid = |win;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port main-memory arbiter for BRK, console and CPU requesters.
// Define MEM_ARB_FAIR_EN to bound CPU starvation at MAX_WAIT consecutive losses.
module mem_arbiter
   import pdp8_mem_pkg::*;
#(
   parameter int AW       = DEF_AW,
   parameter int DW       = DEF_DW,
   parameter int MEM_LAT  = 2,
   parameter int MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_run,
   input  logic          brk_req,
   input  logic          con_req,
   input  logic          cpu_req,
   input  logic          brk_we,
   input  logic          con_we,
   input  logic          cpu_we,
   input  logic [AW-1:0] brk_addr,
   input  logic [AW-1:0] con_addr,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] brk_wdata,
   input  logic [DW-1:0] con_wdata,
   input  logic [DW-1:0] cpu_wdata,
   output logic          brk_gnt,
   output logic          con_gnt,
   output logic          cpu_gnt,
   output logic          brk_done,
   output logic          con_done,
   output logic          cpu_done,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   state_t      state;
   state_t      state_nxt;
   owner_t      owner;
   logic [2:0]  lat_cnt;
   logic [2:0]  win;
   logic        win_valid;
   logic        force_cpu;

   mem_arb_pick u_pick (
      .brk_req   (brk_req),
      .con_req   (con_req),
      .cpu_req   (cpu_req),
      .cpu_run   (cpu_run),
      .force_cpu (force_cpu),
      .win       (win),
      .valid     (win_valid)
   );

`ifdef MEM_ARB_FAIR_EN
   localparam int WCW = $clog2(MAX_WAIT + 1);
   localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

   logic [WCW-1:0] wait_cnt;

   // Counts IDLE evaluations the CPU lost; saturates at the limit until the CPU wins.
   always_ff @(posedge clk) begin
      if (rst || !cpu_req)
         wait_cnt <= '0;
      else if (state == IDLE && win_valid) begin
         if (win[OWN_CPU])
            wait_cnt <= '0;
         else if (wait_cnt != WAIT_LIMIT)
            wait_cnt <= wait_cnt + 1'b1;
      end
   end

   assign force_cpu = (wait_cnt == WAIT_LIMIT);
`else
   assign force_cpu = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      brk_gnt   = 1'b0;
      con_gnt   = 1'b0;
      cpu_gnt   = 1'b0;
      brk_done  = 1'b0;
      con_done  = 1'b0;
      cpu_done  = 1'b0;
      mem_en    = 1'b0;
      case (state)
         IDLE: begin
            if (win_valid)
               state_nxt = ISSUE;
         end
         ISSUE: begin
            mem_en    = 1'b1;
            brk_gnt   = (owner == OWN_BRK);
            con_gnt   = (owner == OWN_CON);
            cpu_gnt   = (owner == OWN_CPU);
            state_nxt = WAIT;
         end
         WAIT: begin
            if (lat_cnt == 3'd1)
               state_nxt = DONE;
         end
         DONE: begin
            brk_done  = (owner == OWN_BRK);
            con_done  = (owner == OWN_CON);
            cpu_done  = (owner == OWN_CPU);
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // Memory-side registers load on the IDLE->ISSUE edge, so they are stable
   // through ISSUE and hold their last values until the next access.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner     <= OWN_BRK;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         lat_cnt   <= '0;
         rdata     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win[OWN_BRK]) begin
                  owner     <= OWN_BRK;
                  mem_we    <= brk_we;
                  mem_addr  <= brk_addr;
                  mem_wdata <= brk_wdata;
               end else if (win[OWN_CON]) begin
                  owner     <= OWN_CON;
                  mem_we    <= con_we;
                  mem_addr  <= con_addr;
                  mem_wdata <= con_wdata;
               end else if (win[OWN_CPU]) begin
                  owner     <= OWN_CPU;
                  mem_we    <= cpu_we;
                  mem_addr  <= cpu_addr;
                  mem_wdata <= cpu_wdata;
               end
            end
            ISSUE: lat_cnt <= 3'(MEM_LAT);
            WAIT: begin
               lat_cnt <= lat_cnt - 3'd1;
               if (lat_cnt == 3'd1)
                  rdata <= mem_rdata;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a 2-cycle pipelined memory model.
// Fairness expectations follow MEM_ARB_FAIR_EN.
module tb_mem_arbiter;

   localparam int L     = 2;
   localparam int O_BRK = 0;
   localparam int O_CON = 1;
   localparam int O_CPU = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_run = 1'b0;
   logic        brk_req = 1'b0, con_req = 1'b0, cpu_req = 1'b0;
   logic        brk_we = 1'b0, con_we = 1'b0, cpu_we = 1'b0;
   logic [14:0] brk_addr = '0, con_addr = '0, cpu_addr = '0;
   logic [11:0] brk_wdata = '0, con_wdata = '0, cpu_wdata = '0;
   logic        brk_gnt, con_gnt, cpu_gnt, brk_done, con_done, cpu_done;
   logic [11:0] rdata;
   logic        busy, mem_en, mem_we;
   logic [14:0] mem_addr;
   logic [11:0] mem_wdata;
   logic [11:0] mem_rdata;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   typedef struct {
      bit          is_done;
      int          owner;
      int          cyc;
      logic [14:0] addr;
      bit          we;
      logic [11:0] wdata;
      bit          chk;
      logic [11:0] data;
   } ev_t;

   ev_t q[$];

   mem_arbiter #(.AW(15), .DW(12), .MEM_LAT(L), .MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst), .cpu_run(cpu_run),
      .brk_req(brk_req), .con_req(con_req), .cpu_req(cpu_req),
      .brk_we(brk_we), .con_we(con_we), .cpu_we(cpu_we),
      .brk_addr(brk_addr), .con_addr(con_addr), .cpu_addr(cpu_addr),
      .brk_wdata(brk_wdata), .con_wdata(con_wdata), .cpu_wdata(cpu_wdata),
      .brk_gnt(brk_gnt), .con_gnt(con_gnt), .cpu_gnt(cpu_gnt),
      .brk_done(brk_done), .con_done(con_done), .cpu_done(cpu_done),
      .rdata(rdata), .busy(busy), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   logic [11:0] mem [0:32767];
   logic [11:0] rd1, rd2;

   always @(posedge clk) begin
      if (rst) begin
         mem[15'o01234] <= 12'o7402;
         rd1 <= '0;
         rd2 <= '0;
      end else begin
         if (mem_en) begin
            rd1 <= mem[mem_addr];
            if (mem_we)
               mem[mem_addr] <= mem_wdata;
         end
         rd2 <= rd1;
      end
   end

   assign mem_rdata = rd2;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0o expected %0o (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_ev(input bit is_done, input int own, input int c, input logic [14:0] a,
                          input bit we, input logic [11:0] wd, input bit chk_d, input logic [11:0] d);
      ev_t e;
      e.is_done = is_done;
      e.owner   = own;
      e.cyc     = c;
      e.addr    = a;
      e.we      = we;
      e.wdata   = wd;
      e.chk     = chk_d;
      e.data    = d;
      q.push_back(e);
   endtask

   // Request seen in IDLE during cycle t: grant at t+1, done at t+2+L.
   task automatic expect_access(input int own, input bit we, input logic [14:0] a,
                                input logic [11:0] wd, input bit chk_d, input logic [11:0] d, input int t);
      push_ev(1'b0, own, t + 1, a, we, wd, 1'b0, 12'o0);
      push_ev(1'b1, own, t + 2 + L, a, we, wd, chk_d, d);
   endtask

   task automatic set_req(input int own, input logic v, input logic we, input logic [14:0] a,
                          input logic [11:0] wd);
      case (own)
         O_BRK: begin
            brk_req = v;
            if (v) begin brk_we = we; brk_addr = a; brk_wdata = wd; end
         end
         O_CON: begin
            con_req = v;
            if (v) begin con_we = we; con_addr = a; con_wdata = wd; end
         end
         default: begin
            cpu_req = v;
            if (v) begin cpu_we = we; cpu_addr = a; cpu_wdata = wd; end
         end
      endcase
   endtask

   task automatic access(input int own, input bit we, input logic [14:0] a, input logic [11:0] wd,
                         input bit chk_d, input logic [11:0] d);
      int t;
      t = cyc;
      set_req(own, 1'b1, we, a, wd);
      expect_access(own, we, a, wd, chk_d, d, t);
      tick();
      tick();
      set_req(own, 1'b0, 1'b0, '0, '0);
      repeat (L + 1) tick();
   endtask

   always @(negedge clk) begin : monitor
      logic [5:0] p;
      ev_t        e;
      int         exp_pat;
      if (!rst) begin
         p = {cpu_done, con_done, brk_done, cpu_gnt, con_gnt, brk_gnt};
         check("mem_en_vs_gnt", 32'(mem_en), 32'(|p[2:0]));
         if (p != 6'b0) begin
            check("one_pulse", 32'($countones(p)), 32'd1);
            if (q.size() == 0) begin
               check("unexpected_pulse", 32'(p), 32'd0);
            end else begin
               e = q.pop_front();
               exp_pat = 1 << (e.owner + (e.is_done ? 3 : 0));
               check("pulse_kind", 32'(p), exp_pat);
               check("pulse_cycle", cyc, e.cyc);
               if (!e.is_done) begin
                  check("mem_addr", 32'(mem_addr), 32'(e.addr));
                  check("mem_we", 32'(mem_we), 32'(e.we));
                  if (e.we)
                     check("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
               end else if (e.chk) begin
                  check("rdata", 32'(rdata), 32'(e.data));
               end
            end
         end
      end
   end

   initial begin : stim
      int t;
      rst = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_mem_en", 32'(mem_en), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      check("rst_pulses", 32'({brk_gnt, con_gnt, cpu_gnt, brk_done, con_done, cpu_done}), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // CPU read of preloaded word
      access(O_CPU, 1'b0, 15'o01234, 12'o0, 1'b1, 12'o7402);

      // Console deposit, then CPU reads it back
      cpu_run = 1'b0;
      access(O_CON, 1'b1, 15'o00200, 12'o0123, 1'b0, 12'o0);
      access(O_CPU, 1'b0, 15'o00200, 12'o0, 1'b1, 12'o0123);

      // Simultaneous BRK and CPU: BRK first, CPU grant L+3 cycles later
      t = cyc;
      set_req(O_BRK, 1'b1, 1'b0, 15'o01234, 12'o0);
      set_req(O_CPU, 1'b1, 1'b0, 15'o00200, 12'o0);
      expect_access(O_BRK, 1'b0, 15'o01234, 12'o0, 1'b1, 12'o7402, t);
      expect_access(O_CPU, 1'b0, 15'o00200, 12'o0, 1'b1, 12'o0123, t + L + 3);
      tick();
      tick();
      set_req(O_BRK, 1'b0, 1'b0, '0, '0);
      repeat (L + 3) tick();
      set_req(O_CPU, 1'b0, 1'b0, '0, '0);
      repeat (L + 1) tick();

      // Console blocked while CPU runs, granted once cpu_run falls
      cpu_run = 1'b1;
      set_req(O_CON, 1'b1, 1'b0, 15'o00200, 12'o0);
      repeat (20) tick();
      cpu_run = 1'b0;
      expect_access(O_CON, 1'b0, 15'o00200, 12'o0, 1'b1, 12'o0123, cyc);
      @(negedge clk);
      check("con_blocked_busy", 32'(busy), 32'd0);
      tick();
      tick();
      set_req(O_CON, 1'b0, 1'b0, '0, '0);
      repeat (L + 1) tick();

      // Reset the cycle after cpu_gnt aborts the access
      t = cyc;
      set_req(O_CPU, 1'b1, 1'b0, 15'o01234, 12'o0);
      push_ev(1'b0, O_CPU, t + 1, 15'o01234, 1'b0, 12'o0, 1'b0, 12'o0);
      tick();
      tick();
      rst = 1'b1;
      set_req(O_CPU, 1'b0, 1'b0, '0, '0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_mem_en", 32'(mem_en), 32'd0);
      repeat (8) tick();
      access(O_CPU, 1'b0, 15'o01234, 12'o0, 1'b1, 12'o7402);

      // Continuous BRK traffic against a waiting CPU
      t = cyc;
      set_req(O_BRK, 1'b1, 1'b0, 15'o01234, 12'o0);
      set_req(O_CPU, 1'b1, 1'b0, 15'o00200, 12'o0);
`ifdef MEM_ARB_FAIR_EN
      for (int i = 0; i < 4; i++)
         expect_access(O_BRK, 1'b0, 15'o01234, 12'o0, 1'b1, 12'o7402, t + i * (L + 3));
      expect_access(O_CPU, 1'b0, 15'o00200, 12'o0, 1'b1, 12'o0123, t + 4 * (L + 3));
      expect_access(O_BRK, 1'b0, 15'o01234, 12'o0, 1'b1, 12'o7402, t + 5 * (L + 3));
      repeat (4 * (L + 3) + 2) tick();
      set_req(O_CPU, 1'b0, 1'b0, '0, '0);
      repeat (L + 6) tick();
      set_req(O_BRK, 1'b0, 1'b0, '0, '0);
`else
      for (int i = 0; i < 10; i++)
         expect_access(O_BRK, 1'b0, 15'o01234, 12'o0, 1'b1, 12'o7402, t + i * (L + 3));
      repeat (50) tick();
      set_req(O_BRK, 1'b0, 1'b0, '0, '0);
      set_req(O_CPU, 1'b0, 1'b0, '0, '0);
`endif
      repeat (6) tick();

      check("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
